// File: rtl/bill_payment_collector.sv
// bill_payment_collector: latches a bill, collects notes, pays greedy change or a cancel refund
module bill_payment_collector (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [12:0] amount_due,
  input  logic        note_valid,
  input  logic [2:0]  note_code,
  input  logic        cancel,
  input  logic        change_ready,
  output logic        busy,
  output logic [13:0] paid,
  output logic [12:0] balance_due,
  output logic        change_valid,
  output logic [2:0]  change_denom,
  output logic        refund,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, COLLECT, CHANGE, DONE} state_t;
  state_t      state_q;
  logic [12:0] due_q, bal_q, owe;
  logic [13:0] paid_q, rem_q, sum, ovr, dval;
  logic        refund_q, covered;
  logic [2:0]  denom;
  function automatic logic [13:0] val(input logic [2:0] c);
    return c == 3'd0 ? 14'd1 : c == 3'd1 ? 14'd2 : c == 3'd2 ? 14'd5 : c == 3'd3 ? 14'd10 :
           c == 3'd4 ? 14'd20 : c == 3'd5 ? 14'd50 : c == 3'd6 ? 14'd100 : 14'd500;
  endfunction
  always_comb begin
    sum     = paid_q + val(note_code);
    covered = sum >= {1'b0, due_q};
    owe     = due_q - sum[12:0];
    ovr     = sum - {1'b0, due_q};
    denom   = rem_q >= 14'd500 ? 3'd7 : rem_q >= 14'd100 ? 3'd6 : rem_q >= 14'd50 ? 3'd5 :
              rem_q >= 14'd20 ? 3'd4 : rem_q >= 14'd10 ? 3'd3 : rem_q >= 14'd5 ? 3'd2 :
              rem_q >= 14'd2 ? 3'd1 : 3'd0;
    dval    = val(denom);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      due_q    <= '0;
      bal_q    <= '0;
      paid_q   <= '0;
      rem_q    <= '0;
      refund_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          due_q    <= amount_due;
          bal_q    <= amount_due;
          paid_q   <= '0;
          refund_q <= 1'b0;
          state_q  <= amount_due == 13'd0 ? DONE : COLLECT;
        end
        COLLECT: if (cancel) begin
          refund_q <= 1'b1;
          rem_q    <= paid_q;
          state_q  <= paid_q != 14'd0 ? CHANGE : DONE;
        end else if (note_valid) begin
          paid_q <= sum;
          bal_q  <= covered ? 13'd0 : owe;
          if (covered) begin
            rem_q   <= ovr;
            state_q <= ovr != 14'd0 ? CHANGE : DONE;
          end
        end
        CHANGE: if (change_ready) begin
          rem_q <= rem_q - dval;
          if (rem_q == dval) state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy         = state_q == COLLECT || state_q == CHANGE;
  assign change_valid = state_q == CHANGE;
  assign change_denom = change_valid ? denom : 3'd0;
  assign done         = state_q == DONE;
  assign paid         = paid_q;
  assign balance_due  = bal_q;
  assign refund       = refund_q;
endmodule

// File: tb/tb_bill_payment_collector.sv
// tb_bill_payment_collector: directed vectors with hand-computed expectations
module tb_bill_payment_collector;
  logic        clk = 0, rst = 1, start = 0, note_valid = 0, cancel = 0, change_ready = 0;
  logic [12:0] amount_due = 0;
  logic [2:0]  note_code = 0;
  logic        busy, change_valid, refund, done;
  logic [13:0] paid;
  logic [12:0] balance_due;
  logic [2:0]  change_denom;
  int n_cmp = 0, n_bad = 0;
  bill_payment_collector dut (
    .clk(clk), .rst(rst), .start(start), .amount_due(amount_due),
    .note_valid(note_valid), .note_code(note_code), .cancel(cancel),
    .change_ready(change_ready), .busy(busy), .paid(paid), .balance_due(balance_due),
    .change_valid(change_valid), .change_denom(change_denom), .refund(refund), .done(done)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic begin_bill(input int due);
    amount_due = 13'(due);
    start = 1;
    tick;
    start = 0;
  endtask
  task automatic note(input int code);
    note_valid = 1;
    note_code = 3'(code);
    tick;
    note_valid = 0;
  endtask
  task automatic take(input string tag, input int code);
    check({tag, "_cv"}, int'(change_valid), 1);
    check({tag, "_denom"}, int'(change_denom), code);
    change_ready = 1;
    tick;
    change_ready = 0;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_paid"}, int'(paid), 0);
    check({tag, "_bal"}, int'(balance_due), 0);
    check({tag, "_cv"}, int'(change_valid), 0);
    check({tag, "_denom"}, int'(change_denom), 0);
    check({tag, "_refund"}, int'(refund), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    tick; tick;
    rst = 0;
    check_zero("reset");
    // overpayment: 83 due, 85 tendered, one 2-note back
    begin_bill(83);
    check("t1_busy", int'(busy), 1);
    check("t1_bal0", int'(balance_due), 83);
    note(5); check("t1_paid50", int'(paid), 50); check("t1_bal33", int'(balance_due), 33);
    note(4); check("t1_paid70", int'(paid), 70);
    note(3); check("t1_bal3", int'(balance_due), 3);
    note(2); check("t1_paid85", int'(paid), 85); check("t1_bal_end", int'(balance_due), 0);
    check("t1_refund", int'(refund), 0);
    take("t1_c0", 1);
    check("t1_done", int'(done), 1);
    check("t1_cv_off", int'(change_valid), 0);
    tick;
    check("t1_done_pulse", int'(done), 0);
    check("t1_paid_hold", int'(paid), 85);
    // greedy 499 with backpressure and ignored start/note in CHANGE
    begin_bill(1);
    note(7);
    check("t2_paid", int'(paid), 500);
    take("t2_c0", 6); take("t2_c1", 6); take("t2_c2", 6); take("t2_c3", 6);
    start = 1; note_valid = 1; note_code = 3'd7; amount_due = 13'd9;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("t2_hold_denom", int'(change_denom), 5);
      check("t2_hold_cv", int'(change_valid), 1);
    end
    start = 0; note_valid = 0;
    check("t2_paid_hold", int'(paid), 500);
    take("t2_c4", 5); take("t2_c5", 4); take("t2_c6", 4); take("t2_c7", 2);
    take("t2_c8", 1); take("t2_c9", 1);
    check("t2_done", int'(done), 1);
    check("t2_refund", int'(refund), 0);
    tick;
    // cancel refund; 500 offered with cancel is ignored, start in COLLECT ignored
    begin_bill(300);
    note(6);
    start = 1; amount_due = 13'd5;
    note(4);
    start = 0;
    check("t3_paid120", int'(paid), 120);
    check("t3_bal180", int'(balance_due), 180);
    cancel = 1;
    note(7);
    cancel = 0;
    check("t3_paid_cancel", int'(paid), 120);
    check("t3_refund", int'(refund), 1);
    take("t3_c0", 6); take("t3_c1", 4);
    check("t3_done", int'(done), 1);
    check("t3_paid_end", int'(paid), 120);
    tick;
    check("t3_refund_hold", int'(refund), 1);
    // zero due
    begin_bill(0);
    check("t4_done", int'(done), 1);
    check("t4_busy", int'(busy), 0);
    check("t4_cv", int'(change_valid), 0);
    check("t4_refund_clr", int'(refund), 0);
    tick;
    check("t4_done_pulse", int'(done), 0);
    // exact pay of maximum bill
    begin_bill(8191);
    for (int i = 0; i < 16; i++) note(7);
    check("t5_paid8000", int'(paid), 8000);
    check("t5_bal191", int'(balance_due), 191);
    note(6); note(5); note(4); note(4);
    check("t5_busy", int'(busy), 1);
    note(0);
    check("t5_paid", int'(paid), 8191);
    check("t5_bal", int'(balance_due), 0);
    check("t5_done", int'(done), 1);
    check("t5_cv", int'(change_valid), 0);
    tick;
    // reset mid-CHANGE, then IDLE ignores note/cancel
    begin_bill(10);
    note(7);
    take("t6_c0", 6); take("t6_c1", 6);
    rst = 1; change_ready = 1;
    tick;
    rst = 0; change_ready = 0;
    check_zero("t6_rst");
    note_valid = 1; note_code = 3'd7; cancel = 1;
    tick;
    note_valid = 0; cancel = 0;
    check_zero("t6_idle");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bill_payment_collector.md
# bill_payment_collector

Payment-side counterpart to the bill amount generator. It latches the final bill amount, accepts tendered notes one per cycle until the bill is covered, and dispenses change greedily, one denomination per handshake. On cancel it refunds everything tendered. It sits between the billing datapath's `final` output and the cash-handling front end.

## Interface

**Parameters**
- none (widths are fixed by the billing datapath: 13-bit amounts).

**Ports**
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a transaction. Sampled in IDLE only.
- `amount_due` input 13: bill amount, unsigned (0..8191). Latched when `start` is accepted.
- `note_valid` input 1: one tendered note is present this cycle.
- `note_code` input 3: denomination code. 0=1, 1=2, 2=5, 3=10, 4=20, 5=50, 6=100, 7=500.
- `cancel` input 1: abort the transaction and refund the amount tendered.
- `change_ready` input 1: the dispenser accepts the presented change note.
- `busy` output 1: high in COLLECT and CHANGE.
- `paid` output 14: running tendered total.
- `balance_due` output 13: amount still owed, saturating at 0.
- `change_valid` output 1: a change note is presented.
- `change_denom` output 3: code of the presented change note (same encoding as `note_code`).
- `refund` output 1: the current or most recent payout is a cancel refund.
- `done` output 1: one-cycle pulse at transaction end.

## Operation

**States:** IDLE, COLLECT, CHANGE, DONE. State is registered.

**Reset** (`rst` high at an edge, in any state, including mid-CHANGE):
- State goes to IDLE.
- `busy`, `paid`, `balance_due`, `change_valid`, `change_denom`, `refund`, `done` all go to 0.
- Internal due and remaining registers clear.
- A change note presented when reset hits is abandoned. No further notes are presented.

**IDLE**
- On `start`: latch `amount_due` into due, clear `paid` and `refund`, and set `balance_due` to `amount_due`.
- If `amount_due` is 0, go to DONE. Otherwise go to COLLECT.
- `note_valid`, `cancel` and `change_ready` are ignored.

**COLLECT**
- Priority: `cancel` before `note_valid`.
- On `cancel`:
  - Any note offered in the same cycle is ignored (not added).
  - Set `refund` to 1 and set remaining to `paid`.
  - Go to CHANGE if `paid` > 0, else go to DONE.
- On `note_valid` (no cancel):
  - Compute sum = `paid` + value(`note_code`). Update `paid` to sum.
  - Update `balance_due` to max(due − sum, 0).
  - If sum ≥ due, set remaining to sum − due. Go to CHANGE if remaining > 0, else go to DONE.
  - Otherwise stay in COLLECT.
- `start` is ignored.

**CHANGE**
- `change_valid` is 1. `change_denom` is the largest denomination ≤ remaining (greedy).
- On `change_ready`: remaining −= value(`change_denom`). If the result is 0, go to DONE.
- With `change_ready` low, `change_denom` and remaining hold.
- `note_valid`, `cancel` and `start` are ignored.

**DONE**
- `done` is 1 for exactly one cycle, then go to IDLE.
- `paid`, `balance_due` and `refund` hold until the next accepted `start`.

**Arithmetic**
- All arithmetic is unsigned.
- `paid` is 14 bits. The maximum is 8190 + 500 = 8690, so it never wraps.
- Remaining is 14 bits. A refund can reach 8190. Overpay change is at most 499.

## Timing

- One note accepted per cycle. `paid` and `balance_due` reflect the note one cycle after it is sampled.
- The transition to CHANGE or DONE happens on the same edge that accepts the covering note or the cancel.
- `change_valid` and `change_denom` are decoded from the registered state and remaining, so they are glitch-free relative to `clk`.
- `change_valid` is first high the cycle after the CHANGE transition.
- Each change note takes at least one cycle. The next denomination appears the cycle after a handshake.
- `done` pulses the cycle after the transition into DONE.
- Minimum transaction with zero due: `start` accepted, then `done` on the next cycle, then IDLE.
- `busy` is low in IDLE and DONE.

## Test plan

- **Overpayment with change.** due=83; tender 50, 20, 10, 5 on consecutive cycles.
  - Required: `paid`=85, `balance_due`=0.
  - Exactly one change note, code 1 (value 2), `refund`=0, then a `done` pulse.
- **Greedy change under backpressure.** due=1; tender 500.
  - Required change sequence: 100, 100, 100, 100, 50, 20, 20, 5, 2, 2 (sums to 499).
  - Hold `change_ready` low 3 cycles mid-sequence: `change_denom` must hold steady.
- **Cancel refund.** due=300; tender 100, then 20; then `cancel` asserted together with `note_valid` (500).
  - Required: the 500 is ignored and `refund`=1.
  - Refund notes 100, 20, then `done`; `paid` stays 120.
- **Zero-due and exact-pay boundaries.**
  - due=0: `done` pulses 1 cycle after `start` and no change is given.
  - due=8191; tender 16×500, then 100, 50, 20, 20, 1: `paid`=8191, no change, `done`.
- **Reset mid-CHANGE.** due=10; tender 500; assert `rst` after 2 change handshakes.
  - Required: all outputs 0 the next cycle, state IDLE.
  - Ignored stimulus: `note_valid` and `cancel` in IDLE have no effect.
- **Ignored inputs.** `start` pulsed during COLLECT and CHANGE, and `note_valid` during CHANGE.
  - Required: due, `paid` and the change sequence are unaffected.
